// File: rtl/sub_pipe_if.sv
// Operand/result handshake bundle for sub_pipe.
// Carries the input valid/ready pair with a, b, bin, and the output valid/ready pair with d, bout.
// The ovf wire exists only when SUB_PIPE_OVF_EN is defined.
interface sub_pipe_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic             bout;
`ifdef SUB_PIPE_OVF_EN
    logic             ovf;
`endif

    // Producer/consumer side: drives operands and out_ready, observes results.
    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, d, bout
`ifdef SUB_PIPE_OVF_EN
        , input ovf
`endif
    );

    // Subtractor side.
    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, d, bout
`ifdef SUB_PIPE_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/sub_pipe.sv
// Pipelined chunked subtractor {bout, d} = a - b - bin, one op per cycle, borrow rippling through STAGES slices.
// Latency: result valid STAGES-1 edges after acceptance; each stalled cycle adds one.
// Backpressure: global advance = !out_valid | out_ready; in_ready = advance, and the whole pipe holds when it is low.
//
// Ports: clk, rst_n (async, active-low), io (sub_pipe_if.slave: in_valid/in_ready/a/b/bin, out_valid/out_ready/d/bout).
// Optional macro SUB_PIPE_OVF_EN adds io.ovf, the signed overflow flag aligned with d.
// Requires STAGES >= 2 and WIDTH divisible by STAGES.
module sub_pipe #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    sub_pipe_if.slave  io
);
    localparam int CW  = WIDTH / STAGES;
    localparam int CW1 = CW + 1;

    // Per-stage valid and borrow-out of that stage's slice.
    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] brw_q, brw_d;
    // Result accumulator: stage k holds chunks 0..k of its operation in place.
    logic [WIDTH-1:0]  d_q [STAGES];
    logic [WIDTH-1:0]  d_d [STAGES];
    // Operand skew: not-yet-consumed chunks, shifted so the next slice's chunk sits at bit 0.
    logic [WIDTH-1:0]  a_q [STAGES-1];
    logic [WIDTH-1:0]  a_d [STAGES-1];
    logic [WIDTH-1:0]  b_q [STAGES-1];
    logic [WIDTH-1:0]  b_d [STAGES-1];
    // Slice subtract results; bit CW is the borrow (difference went negative).
    logic [CW:0]       diff [STAGES];
    logic              adv;
`ifdef SUB_PIPE_OVF_EN
    logic              ovf_q, ovf_d;
    logic              sign_a, sign_b, sign_d;
`endif

    always_comb begin
        adv   = !vld_q[STAGES-1] || io.out_ready;
        vld_d = vld_q;
        brw_d = brw_q;
        d_d   = d_q;
        a_d   = a_q;
        b_d   = b_q;

        diff[0] = {1'b0, io.a[CW-1:0]} - {1'b0, io.b[CW-1:0]} - CW1'(io.bin);
        for (int k = 1; k < STAGES; k++) begin
            diff[k] = {1'b0, a_q[k-1][CW-1:0]} - {1'b0, b_q[k-1][CW-1:0]} - CW1'(brw_q[k-1]);
        end

        if (adv) begin
            // in_ready equals adv, so stage 0 takes in_valid directly.
            vld_d[0] = io.in_valid;
            brw_d[0] = diff[0][CW];
            d_d[0]   = WIDTH'(diff[0][CW-1:0]);
            a_d[0]   = io.a >> CW;
            b_d[0]   = io.b >> CW;
            for (int k = 1; k < STAGES; k++) begin
                vld_d[k]             = vld_q[k-1];
                brw_d[k]             = diff[k][CW];
                d_d[k]               = d_q[k-1];
                d_d[k][k*CW +: CW]   = diff[k][CW-1:0];
            end
            for (int k = 1; k < STAGES-1; k++) begin
                a_d[k] = a_q[k-1] >> CW;
                b_d[k] = b_q[k-1] >> CW;
            end
        end
    end

`ifdef SUB_PIPE_OVF_EN
    // Top slice sees the operand sign bits at the MSB of its chunk.
    always_comb begin
        sign_a = a_q[STAGES-2][CW-1];
        sign_b = b_q[STAGES-2][CW-1];
        sign_d = diff[STAGES-1][CW-1];
        ovf_d  = ovf_q;
        if (adv) begin
            ovf_d = (sign_a ^ sign_b) & (sign_d ^ sign_a);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign io.ovf = ovf_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            brw_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                d_q[k] <= '0;
            end
            for (int k = 0; k < STAGES-1; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            brw_q <= brw_d;
            d_q   <= d_d;
            a_q   <= a_d;
            b_q   <= b_d;
        end
    end

    assign io.in_ready  = adv;
    assign io.out_valid = vld_q[STAGES-1];
    assign io.d         = d_q[STAGES-1];
    assign io.bout      = brw_q[STAGES-1];
endmodule
